// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave register-bus bridge:
//   state_e   - frame decoder states (IDLE/HEADER/FETCH/DATA/HOLD)
//   RW_WRITE  - value of the first frame bit that selects a write
//   RW_READ   - value of the first frame bit that selects a read
// No ports.
// -----------------------------------------------------------------------------
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_FETCH  = 3'd2,
      ST_DATA   = 3'd3,
      ST_HOLD   = 3'd4
   } state_e;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous input into the clk domain through SYNC_STAGES flops,
// then one more flop that remembers the previous synchronised level so that
// single-cycle rise/fall pulses can be derived.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   din   in   asynchronous input
//   sync  out  synchronised level
//   rise  out  1-clk pulse on a synchronised 0->1 transition
//   fall  out  1-clk pulse on a synchronised 1->0 transition
// RST_VAL is the level the chain assumes during reset.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   edge_r;

   // synchroniser chain followed by the edge-detect flop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain_r <= {SYNC_STAGES{RST_VAL}};
         edge_r  <= RST_VAL;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], din};
         edge_r  <= chain_r[SYNC_STAGES-1];
      end
   end

   assign sync = chain_r[SYNC_STAGES-1];
   assign rise = sync & ~edge_r;
   assign fall = ~sync & edge_r;

endmodule

// File: rtl/spi_slave_regif.sv
// -----------------------------------------------------------------------------
// spi_slave_regif
// SPI mode-0 slave to register-bus bridge. A frame is {RW, ADDR, DATA}, MSB
// first; writes produce a 1-clk wr_en strobe, reads a 1-clk rd_en strobe whose
// data (rd_data, sampled one clk after rd_en) is shifted out on miso.
// Optional feature macro: SPI_BURST_EN - keep transferring words while cs_n is
// low, incrementing (and wrapping) the address after every word.
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   sck, cs_n, mosi     asynchronous SPI inputs (oversampled)
//   miso, miso_oe       serial data out and its pad enable
//   addr                register address, valid with rd_en/wr_en
//   wr_en, wr_data      write strobe and data
//   rd_en, rd_data      read strobe and returned data
//   busy                frame in progress
//   frame_err           1-clk pulse when cs_n rises inside a header or word
// -----------------------------------------------------------------------------
module spi_slave_regif
   import spi_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] addr,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(1 + ADDR_W + DATA_W);

   logic sck_level_unused, sck_rise_s, sck_fall_s;
   logic cs_sync_s, cs_rise_s, cs_fall_s;
   logic mosi_sync_s, mosi_rise_unused, mosi_fall_unused;

   // cs_n chain resets low so that a select held low across reset never
   // looks like a fresh falling edge; a frame needs a real high-to-low.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .din(sck),
      .sync(sck_level_unused), .rise(sck_rise_s), .fall(sck_fall_s));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
      .clk(clk), .rst(rst), .din(cs_n),
      .sync(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .din(mosi),
      .sync(mosi_sync_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   state_e            state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [ADDR_W-1:0] hdr_r, hdr_nxt_s;
   logic              rw_r, rw_nxt_s;
   logic [ADDR_W-1:0] addr_r, addr_nxt_s;
   logic [DATA_W-1:0] sr_r, sr_nxt_s;
   logic              ph_r, ph_nxt_s;
   logic              miso_r, miso_nxt_s;
   logic              wr_en_r, wr_en_nxt_s;
   logic [DATA_W-1:0] wr_data_r, wr_data_nxt_s;
   logic              rd_en_r, rd_en_nxt_s;
   logic              err_r, err_nxt_s;
   logic              busy_r, oe_r, armed_r;

   // frame decoder: next state, datapath updates and strobes
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      hdr_nxt_s     = hdr_r;
      rw_nxt_s      = rw_r;
      addr_nxt_s    = addr_r;
      sr_nxt_s      = sr_r;
      ph_nxt_s      = ph_r;
      miso_nxt_s    = miso_r;
      wr_en_nxt_s   = 1'b0;
      wr_data_nxt_s = wr_data_r;
      rd_en_nxt_s   = 1'b0;
      err_nxt_s     = 1'b0;
`ifdef SPI_BURST_EN
      // a burst write advances the address once its strobe has been seen
      if (wr_en_r) begin
         addr_nxt_s = addr_r + ADDR_W'(1);
      end else begin
         addr_nxt_s = addr_r;
      end
`endif
      if (cs_rise_s && (state_r != ST_IDLE)) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = '0;
         miso_nxt_s  = 1'b0;
         // only a header or word cut part-way through is an error
         err_nxt_s   = ((state_r == ST_HEADER) || (state_r == ST_DATA)) && (cnt_r != '0);
      end else begin
         case (state_r)
            ST_IDLE: begin
               miso_nxt_s = 1'b0;
               if (cs_fall_s) begin
                  state_nxt_s = ST_HEADER;
                  cnt_nxt_s   = '0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_HEADER: begin
               if (sck_rise_s) begin
                  hdr_nxt_s = {hdr_r[ADDR_W-2:0], mosi_sync_s};
                  if (cnt_r == CNT_W'(ADDR_W)) begin
                     // hdr_r still holds RW in its top bit at this point
                     rw_nxt_s   = hdr_r[ADDR_W-1];
                     addr_nxt_s = {hdr_r[ADDR_W-2:0], mosi_sync_s};
                     cnt_nxt_s  = '0;
                     if (hdr_r[ADDR_W-1] == RW_WRITE) begin
                        state_nxt_s = ST_DATA;
                     end else begin
                        state_nxt_s = ST_FETCH;
                        ph_nxt_s    = 1'b0;
                        rd_en_nxt_s = 1'b1;
                     end
                  end else begin
                     cnt_nxt_s = cnt_r + CNT_W'(1);
                  end
               end else begin
                  state_nxt_s = ST_HEADER;
               end
            end
            ST_FETCH: begin
               // phase 0: rd_en visible; phase 1: register file answers
               if (ph_r == 1'b0) begin
                  ph_nxt_s = 1'b1;
               end else begin
                  sr_nxt_s    = rd_data;
                  ph_nxt_s    = 1'b0;
                  cnt_nxt_s   = '0;
                  state_nxt_s = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sck_fall_s && (rw_r == RW_READ)) begin
                  miso_nxt_s = sr_r[DATA_W-1];
                  sr_nxt_s   = {sr_r[DATA_W-2:0], 1'b0};
               end else if (sck_rise_s) begin
                  if (rw_r == RW_WRITE) begin
                     sr_nxt_s = {sr_r[DATA_W-2:0], mosi_sync_s};
                  end else begin
                     sr_nxt_s = sr_r;
                  end
                  if (cnt_r == CNT_W'(DATA_W - 1)) begin
                     cnt_nxt_s = '0;
                     if (rw_r == RW_WRITE) begin
                        wr_en_nxt_s   = 1'b1;
                        wr_data_nxt_s = {sr_r[DATA_W-2:0], mosi_sync_s};
                     end else begin
                        wr_en_nxt_s = 1'b0;
                     end
`ifdef SPI_BURST_EN
                     if (rw_r == RW_READ) begin
                        // prefetch the next word while the master samples this bit
                        state_nxt_s = ST_FETCH;
                        ph_nxt_s    = 1'b0;
                        rd_en_nxt_s = 1'b1;
                        addr_nxt_s  = addr_r + ADDR_W'(1);
                     end else begin
                        state_nxt_s = ST_DATA;
                     end
`else
                     state_nxt_s = ST_HOLD;
                     miso_nxt_s  = 1'b0;
`endif
                  end else begin
                     cnt_nxt_s = cnt_r + CNT_W'(1);
                  end
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            ST_HOLD: begin
               miso_nxt_s = 1'b0;
            end
            default: begin
               state_nxt_s = ST_IDLE;
               miso_nxt_s  = 1'b0;
            end
         endcase
      end
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         hdr_r     <= '0;
         rw_r      <= 1'b0;
         addr_r    <= '0;
         sr_r      <= '0;
         ph_r      <= 1'b0;
         miso_r    <= 1'b0;
         wr_en_r   <= 1'b0;
         wr_data_r <= '0;
         rd_en_r   <= 1'b0;
         err_r     <= 1'b0;
         busy_r    <= 1'b0;
         oe_r      <= 1'b0;
         armed_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         hdr_r     <= hdr_nxt_s;
         rw_r      <= rw_nxt_s;
         addr_r    <= addr_nxt_s;
         sr_r      <= sr_nxt_s;
         ph_r      <= ph_nxt_s;
         miso_r    <= miso_nxt_s;
         wr_en_r   <= wr_en_nxt_s;
         wr_data_r <= wr_data_nxt_s;
         rd_en_r   <= rd_en_nxt_s;
         err_r     <= err_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
         // pad stays disabled until cs_n has been seen high since reset
         oe_r      <= ~cs_sync_s & armed_r;
         armed_r   <= armed_r | cs_sync_s;
      end
   end

   assign miso      = miso_r;
   assign miso_oe   = oe_r;
   assign addr      = addr_r;
   assign wr_en     = wr_en_r;
   assign wr_data   = wr_data_r;
   assign rd_en     = rd_en_r;
   assign busy      = busy_r;
   assign frame_err = err_r;

endmodule

// File: tb/tb_spi_slave_regif.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regif
// Drives SPI mode-0 frames (clk = 8x sck) into spi_slave_regif, emulates a
// register file for reads and compares the observed strobes, miso stream and
// frame errors with expectations from a frame-level reference model and from
// a table of directed vectors.
// -----------------------------------------------------------------------------
module tb_spi_slave_regif;

   localparam int AW  = 7;
   localparam int DW  = 8;
   localparam int HDR = 1 + AW;
`ifdef SPI_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sck = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic          miso, miso_oe, wr_en, rd_en, busy, frame_err;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;

   spi_slave_regif #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .addr(addr), .wr_en(wr_en),
      .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .busy(busy),
      .frame_err(frame_err));

   always #5 clk = ~clk;

   logic [DW-1:0] rd_mem [0:127];

   // register file: answers a read strobe on the following clock
   always @(posedge clk or negedge rst) begin
      if (!rst) rd_data <= '0;
      else if (rd_en) rd_data <= rd_mem[addr];
   end

   int n_checks = 0;
   int n_fail = 0;
   logic [AW+DW-1:0] act_wr_q[$], exp_wr_q[$];
   logic [AW-1:0]    act_rd_q[$], exp_rd_q[$];
   int act_err, exp_err, conflicts;
   logic [63:0] ftx, act_rx, exp_rx;
   int fn;

   // observe strobes between clock edges
   always @(negedge clk) begin
      if (rst) begin
         if (wr_en) act_wr_q.push_back({addr, wr_data});
         if (rd_en) act_rd_q.push_back(addr);
         if (frame_err) act_err++;
         if ((wr_en && rd_en) || ((wr_en || rd_en) && frame_err)) conflicts++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      act_wr_q.delete();
      act_rd_q.delete();
      act_err = 0;
      conflicts = 0;
      act_rx = '0;
   endtask

   task automatic add_bits(input logic [31:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) begin
         ftx[fn] = v[i];
         fn++;
      end
   endtask

   // frame-level expectations derived from the bit list ftx[0..fn-1]
   task automatic model();
      logic          rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int nd, full, rem, used, nrd, wi;
      exp_wr_q.delete();
      exp_rd_q.delete();
      exp_err = 0;
      exp_rx = '0;
      if (fn < HDR) begin
         exp_err = (fn > 0) ? 1 : 0;
      end else begin
         rw = ftx[0];
         a = '0;
         for (int i = 1; i < HDR; i++) a = {a[AW-2:0], ftx[i]};
         nd = fn - HDR;
         full = nd / DW;
         rem = nd % DW;
         used = BURST ? full : ((full >= 1) ? 1 : 0);
         exp_err = (rem > 0 && (BURST || full == 0)) ? 1 : 0;
         if (rw) begin
            for (int w = 0; w < used; w++) begin
               d = '0;
               for (int k = 0; k < DW; k++) d = {d[DW-2:0], ftx[HDR + w*DW + k]};
               exp_wr_q.push_back({a + AW'(w), d});
            end
         end else begin
            nrd = BURST ? full + 1 : 1;
            for (int w = 0; w < nrd; w++) exp_rd_q.push_back(a + AW'(w));
            for (int j = 0; j < nd; j++) begin
               wi = j / DW;
               if (BURST || wi == 0) exp_rx[HDR + j] = rd_mem[a + AW'(wi)][DW - 1 - (j % DW)];
            end
         end
      end
   endtask

   task automatic sck_bit(input logic b, output logic m);
      mosi = b;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      m = miso;
      repeat (4) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic run_frame();
      logic m;
      check("oe_idle", 64'(miso_oe), 64'd0);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      check("oe_active", 64'(miso_oe), 64'd1);
      check("busy_active", 64'(busy), 64'd1);
      for (int i = 0; i < fn; i++) begin
         sck_bit(ftx[i], m);
         act_rx[i] = m;
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      check("busy_after", 64'(busy), 64'd0);
   endtask

   task automatic compare(input string tag);
      check({tag, "_nwr"}, 64'(act_wr_q.size()), 64'(exp_wr_q.size()));
      for (int i = 0; i < act_wr_q.size() && i < exp_wr_q.size(); i++)
         check({tag, "_wr"}, 64'(act_wr_q[i]), 64'(exp_wr_q[i]));
      check({tag, "_nrd"}, 64'(act_rd_q.size()), 64'(exp_rd_q.size()));
      for (int i = 0; i < act_rd_q.size() && i < exp_rd_q.size(); i++)
         check({tag, "_rd"}, 64'(act_rd_q[i]), 64'(exp_rd_q[i]));
      check({tag, "_err"}, 64'(act_err), 64'(exp_err));
      check({tag, "_miso"}, act_rx, exp_rx);
      check({tag, "_conflict"}, 64'(conflicts), 64'd0);
   endtask

   typedef struct {
      logic          rw;
      logic [AW-1:0] a;
      int            nw;
      logic [15:0]   d;
      int            cut;
      int            e_wr;
      logic [14:0]   e_wr0;
      int            e_rd;
      logic [AW-1:0] e_rd0;
      int            e_err;
      logic [7:0]    e_rx0;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic m;
      logic [7:0] rx0;
      logic [AW-1:0] ra;
      int nw, cut;

      for (int i = 0; i < 128; i++) rd_mem[i] = DW'($urandom);
      rd_mem[7'h03] = 8'h3C;
      rd_mem[7'h10] = 8'hC3;
      rd_mem[7'h11] = 8'h81;
      rd_mem[7'h7F] = 8'h96;

      vecs[0] = '{1'b1, 7'h15, 1, 16'hA500, 0, 1, {7'h15, 8'hA5}, 0, 7'h00, 0, 8'h00};
      vecs[1] = '{1'b0, 7'h03, 1, 16'h0000, 0, 0, 15'h0, BURST ? 2 : 1, 7'h03, 0, 8'h3C};
      vecs[2] = '{1'b1, 7'h20, 1, 16'hB600, 3, 0, 15'h0, 0, 7'h00, 1, 8'h00};
      vecs[3] = '{1'b1, 7'h7F, 2, 16'h1122, 0, BURST ? 2 : 1, {7'h7F, 8'h11}, 0, 7'h00, 0, 8'h00};
      vecs[4] = '{1'b0, 7'h10, 2, 16'h0000, 0, 0, 15'h0, BURST ? 3 : 1, 7'h10, 0, 8'hC3};
      vecs[5] = '{1'b1, 7'h05, 0, 16'h0000, 4, 0, 15'h0, 0, 7'h00, 1, 8'h00};
      vecs[6] = '{1'b0, 7'h7F, 1, 16'h0000, 0, 0, 15'h0, BURST ? 2 : 1, 7'h7F, 0, 8'h96};

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({miso, miso_oe, addr, wr_en, wr_data, rd_en, busy, frame_err}), 64'd0);
      rst = 1'b1;
      repeat (6) @(negedge clk);

      // directed table
      for (int v = 0; v < 7; v++) begin
         clear_obs();
         fn = 0;
         add_bits(32'(vecs[v].rw), 1);
         add_bits(32'(vecs[v].a), AW);
         if (vecs[v].nw >= 1) add_bits(32'(vecs[v].d[15:8]), DW);
         if (vecs[v].nw >= 2) add_bits(32'(vecs[v].d[7:0]), DW);
         fn = fn - vecs[v].cut;
         model();
         run_frame();
         check("tbl_nwr", 64'(act_wr_q.size()), 64'(vecs[v].e_wr));
         if (act_wr_q.size() > 0 && vecs[v].e_wr > 0) check("tbl_wr0", 64'(act_wr_q[0]), 64'(vecs[v].e_wr0));
         check("tbl_nrd", 64'(act_rd_q.size()), 64'(vecs[v].e_rd));
         if (act_rd_q.size() > 0 && vecs[v].e_rd > 0) check("tbl_rd0", 64'(act_rd_q[0]), 64'(vecs[v].e_rd0));
         check("tbl_err", 64'(act_err), 64'(vecs[v].e_err));
         rx0 = '0;
         for (int k = 0; k < DW; k++) rx0 = {rx0[6:0], act_rx[HDR + k]};
         check("tbl_rx0", 64'(rx0), 64'(vecs[v].e_rx0));
         compare("tbl_model");
      end

      // reset in the middle of a header, select still low afterwards
      clear_obs();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      sck_bit(1'b1, m);
      sck_bit(1'b0, m);
      sck_bit(1'b1, m);
      rst = 1'b0;
      sck_bit(1'b1, m);
      check("midreset_outputs", 64'({miso, miso_oe, addr, wr_en, wr_data, rd_en, busy, frame_err}), 64'd0);
      clear_obs();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) sck_bit(1'b1, m);
      check("midreset_busy", 64'(busy), 64'd0);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midreset_silent", 64'({act_wr_q.size() == 0, act_rd_q.size() == 0, act_err == 0}), 64'd7);
      clear_obs();
      fn = 0;
      add_bits(32'd1, 1);
      add_bits(32'h01, AW);
      add_bits(32'h5A, DW);
      model();
      run_frame();
      check("postreset_wr", (act_wr_q.size() > 0) ? 64'(act_wr_q[0]) : 64'h0, 64'({7'h01, 8'h5A}));
      compare("postreset");

      // randomized frames against the model
      for (int t = 0; t < 30; t++) begin
         clear_obs();
         fn = 0;
         ra = AW'($urandom);
         if ((t % 6) == 0) ra = 7'h7F;
         nw = $urandom_range(1, 3);
         add_bits(32'($urandom_range(0, 1)), 1);
         add_bits(32'(ra), AW);
         for (int w = 0; w < nw; w++) add_bits(32'($urandom_range(0, 255)), DW);
         cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, AW + DW * nw) : 0;
         fn = fn - cut;
         model();
         run_frame();
         compare("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
